// File: rtl/rnd_checker.sv
// ---------------------------------------------------------------------------
// rnd_checker
//
// Receive-side checker for the 16-bit Galois LFSR stream produced by the NTS
// pseudo-random source (right-shift form, feedback polynomial POLY).
//
// The checker self-synchronises on the incoming word stream:
//   HUNT   - wait for any nonzero word and seed the predictor from it
//   SYNC   - count consecutive correct predictions; LOCK_CNT of them lock
//   LOCKED - flywheel the predictor, count word errors, and fall back to
//            HUNT after LOSS_CNT consecutive misses
//
// Optional build macro RND_CHK_BITERR_EN adds the BitErrCnt output, which
// accumulates the number of differing bits on each locked mismatch.
// ---------------------------------------------------------------------------
module rnd_checker #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] POLY     = 16'hD35B,
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               ERR_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    input  logic [WIDTH-1:0] InData,
    input  logic             Clear,
    output logic             Locked,
    output logic             ErrPulse,
    output logic [ERR_W-1:0] ErrCnt
`ifdef RND_CHK_BITERR_EN
    ,
    output logic [ERR_W-1:0] BitErrCnt
`endif
);

    // Run/miss counters are 4 bits wide, so the thresholds live in 4 bits too
    localparam logic [3:0]       LOCK_LIM = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_LIM = 4'(LOSS_CNT);
    localparam logic [3:0]       CNT_ONE  = 4'd1;
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // One LFSR advance: shift right, fold the polynomial in when bit 0 was set
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
        return {1'b0, x[WIDTH-1:1]} ^ (x[0] ? POLY : {WIDTH{1'b0}});
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] step_in;
    logic [WIDTH-1:0] step_exp;
    logic             in_match;
    logic             in_zero;
    logic             lock_err;

    assign step_in  = lfsr_step(InData);
    assign step_exp = lfsr_step(exp_q);
    assign in_match = (InData == exp_q);
    assign in_zero  = (InData == {WIDTH{1'b0}});
    assign lock_err = InValid && (state_q == LOCKED) && !in_match;

    // State register: HUNT after reset, otherwise follow the next-state logic
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only valid words move the FSM
    always_comb begin
        state_d = state_q;
        if (InValid) begin
            case (state_q)
                HUNT: begin
                    if (!in_zero) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (in_match) begin
                        if ((run_q + CNT_ONE) == LOCK_LIM) begin
                            state_d = LOCKED;
                        end
                    end else if (in_zero) begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (!in_match && ((miss_q + CNT_ONE) == LOSS_LIM)) begin
                        state_d = HUNT;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Predictor and run/miss counters: seed in HUNT/SYNC, flywheel when locked
    always_comb begin
        exp_d  = exp_q;
        run_d  = run_q;
        miss_d = miss_q;
        if (InValid) begin
            case (state_q)
                HUNT: begin
                    if (!in_zero) begin
                        exp_d = step_in;
                        run_d = '0;
                    end
                end
                SYNC: begin
                    if (in_match) begin
                        exp_d  = step_in;
                        run_d  = run_q + CNT_ONE;
                        miss_d = '0;
                    end else if (!in_zero) begin
                        exp_d = step_in;
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    exp_d = step_exp;
                    if (in_match) begin
                        miss_d = '0;
                    end else if ((miss_q + CNT_ONE) == LOSS_LIM) begin
                        miss_d = '0;
                    end else begin
                        miss_d = miss_q + CNT_ONE;
                    end
                end
                default: begin
                    run_d  = '0;
                    miss_d = '0;
                end
            endcase
        end
    end

    // Outputs: lock flag tracks the next state, errors pulse and count once
    always_comb begin
        locked_d    = (state_d == LOCKED);
        err_pulse_d = lock_err;
        err_cnt_d   = err_cnt_q;
        if (Clear) begin
            err_cnt_d = lock_err ? ERR_ONE : {ERR_W{1'b0}};
        end else if (lock_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            exp_q       <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            exp_q       <= exp_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign Locked   = locked_q;
    assign ErrPulse = err_pulse_q;
    assign ErrCnt   = err_cnt_q;

`ifdef RND_CHK_BITERR_EN
    // Popcount of a full word needs enough bits to hold WIDTH itself
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((ERR_W > PC_W) ? ERR_W : PC_W) + 1;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

    logic [ERR_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
    logic [SUM_W-1:0] pop_ext;
    logic [SUM_W-1:0] bit_sum;

    // Bit error accumulator: widened add so saturation can be detected
    always_comb begin
        pop_ext       = SUM_W'(popcount(InData ^ exp_q));
        bit_sum       = SUM_W'(bit_err_cnt_q) + pop_ext;
        bit_err_cnt_d = bit_err_cnt_q;
        if (Clear) begin
            if (lock_err) begin
                bit_err_cnt_d = (pop_ext > SUM_W'(ERR_MAX)) ? ERR_MAX : pop_ext[ERR_W-1:0];
            end else begin
                bit_err_cnt_d = '0;
            end
        end else if (lock_err) begin
            bit_err_cnt_d = (bit_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : bit_sum[ERR_W-1:0];
        end
    end

    // Bit error register, same timing as the word error counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_err_cnt_q <= '0;
        end else begin
            bit_err_cnt_q <= bit_err_cnt_d;
        end
    end

    assign BitErrCnt = bit_err_cnt_q;
`endif

endmodule

// File: tb/tb_rnd_checker.sv
// ---------------------------------------------------------------------------
// tb_rnd_checker
//
// Drives rnd_checker (ERR_W=4 so saturation is reachable) with vector tables
// and hand-built sequences. Every driven cycle pushes the outputs expected
// one clock later onto a scoreboard queue, popped and compared after the edge.
// Build with RND_CHK_BITERR_EN defined to also check BitErrCnt.
// ---------------------------------------------------------------------------
module tb_rnd_checker;

    localparam int WIDTH = 16;
    localparam int ERR_W = 4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             InValid;
    logic [WIDTH-1:0] InData;
    logic             Clear;
    logic             Locked;
    logic             ErrPulse;
    logic [ERR_W-1:0] ErrCnt;
`ifdef RND_CHK_BITERR_EN
    logic [ERR_W-1:0] BitErrCnt;
`endif

    rnd_checker #(
        .WIDTH    (WIDTH),
        .POLY     (16'hD35B),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .ERR_W    (ERR_W)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InValid  (InValid),
        .InData   (InData),
        .Clear    (Clear),
        .Locked   (Locked),
        .ErrPulse (ErrPulse),
        .ErrCnt   (ErrCnt)
`ifdef RND_CHK_BITERR_EN
        ,
        .BitErrCnt(BitErrCnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic        clear;
        logic [15:0] data;
        logic        locked;
        logic        pulse;
        logic [3:0]  cnt;
        logic [3:0]  bits;
    } vec_t;

    typedef struct packed {
        logic       locked;
        logic       pulse;
        logic [3:0] cnt;
        logic [3:0] bits;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    string phase  = "init";

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hD35B : 16'h0000);
    endfunction

    function automatic vec_t mk(input int rst, input int valid, input int clear,
                                input logic [15:0] data, input int locked,
                                input int pulse, input int cnt, input int bits);
        vec_t v;
        v.rst    = (rst != 0);
        v.valid  = (valid != 0);
        v.clear  = (clear != 0);
        v.data   = data;
        v.locked = (locked != 0);
        v.pulse  = (pulse != 0);
        v.cnt    = 4'(cnt);
        v.bits   = 4'(bits);
        return v;
    endfunction

    // valid word, idle bubble (garbage data), reset, clear-only bubble
    function automatic vec_t wv(input logic [15:0] d, input int l, input int p, input int c, input int b);
        return mk(0, 1, 0, d, l, p, c, b);
    endfunction
    function automatic vec_t iv(input int l, input int p, input int c, input int b);
        return mk(0, 0, 0, 16'hDEAD, l, p, c, b);
    endfunction
    function automatic vec_t rv();
        return mk(1, 0, 0, 16'hDEAD, 0, 0, 0, 0);
    endfunction
    function automatic vec_t cv(input int l);
        return mk(0, 0, 1, 16'hDEAD, l, 0, 0, 0);
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s/%s: actual=%0h required=%0h", phase, name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        Rst     = v.rst;
        InValid = v.valid;
        Clear   = v.clear;
        InData  = v.data;
        e.locked = v.locked;
        e.pulse  = v.pulse;
        e.cnt    = v.cnt;
        e.bits   = v.bits;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s/scoreboard: actual=empty required=entry", phase);
        end else begin
            e = sb.pop_front();
            cmp("Locked",   16'(Locked),   16'(e.locked));
            cmp("ErrPulse", 16'(ErrPulse), 16'(e.pulse));
            cmp("ErrCnt",   16'(ErrCnt),   16'(e.cnt));
`ifdef RND_CHK_BITERR_EN
            cmp("BitErrCnt", 16'(BitErrCnt), 16'(e.bits));
`endif
        end
    endtask

    task automatic cycle(input vec_t v);
        applyStimulus(v);
        @(posedge Clk);
        #1;
        checkOutput();
    endtask

    task automatic runTable();
        foreach (vecs[i]) begin
            cycle(vecs[i]);
        end
        vecs.delete();
    endtask

    initial begin
        logic [15:0] nxt;
        int          n;
        int          sat;

        Rst     = 1'b1;
        InValid = 1'b0;
        InData  = '0;
        Clear   = 1'b0;

        // Lock on FFFF..C6CF, then one flywheel error, clear, and loss of lock
        phase = "lock";
        vecs.push_back(rv());
        vecs.push_back(wv(16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(wv(16'hACA4, 0, 0, 0, 0));
        vecs.push_back(wv(16'h5652, 0, 0, 0, 0));
        vecs.push_back(wv(16'h2B29, 0, 0, 0, 0));
        vecs.push_back(wv(16'hC6CF, 1, 0, 0, 0));
        vecs.push_back(iv(1, 0, 0, 0));
        runTable();

        phase = "single_err";
        vecs.push_back(wv(16'hB03D, 1, 1, 1, 1));
        vecs.push_back(wv(16'h581E, 1, 0, 1, 1));
        vecs.push_back(wv(16'h2C0F, 1, 0, 1, 1));
        vecs.push_back(iv(1, 0, 1, 1));
        vecs.push_back(cv(1));
        runTable();

        phase = "loss";
        vecs.push_back(wv(16'h1111, 1, 1, 1, 8));
        vecs.push_back(wv(16'h2222, 1, 1, 2, 12));
        vecs.push_back(wv(16'h3333, 0, 1, 3, 15));
        vecs.push_back(iv(0, 0, 3, 15));
        vecs.push_back(wv(16'h0000, 0, 0, 3, 15));
        runTable();

        // Zero words are ignored while hunting
        phase = "zero_hunt";
        vecs.push_back(rv());
        vecs.push_back(wv(16'h0000, 0, 0, 0, 0));
        vecs.push_back(wv(16'h0000, 0, 0, 0, 0));
        vecs.push_back(wv(16'h0000, 0, 0, 0, 0));
        vecs.push_back(wv(16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(wv(16'hACA4, 0, 0, 0, 0));
        vecs.push_back(wv(16'h5652, 0, 0, 0, 0));
        vecs.push_back(wv(16'h2B29, 0, 0, 0, 0));
        vecs.push_back(wv(16'hC6CF, 1, 0, 0, 0));
        runTable();

        // A mismatch in SYNC reseeds and restarts the run
        phase = "sync_reseed";
        vecs.push_back(rv());
        vecs.push_back(wv(16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(wv(16'hACA4, 0, 0, 0, 0));
        vecs.push_back(wv(16'h1234, 0, 0, 0, 0));
        vecs.push_back(wv(16'h091A, 0, 0, 0, 0));
        vecs.push_back(wv(16'h048D, 0, 0, 0, 0));
        vecs.push_back(wv(16'hD11D, 0, 0, 0, 0));
        vecs.push_back(wv(16'hBBD5, 1, 0, 0, 0));
        runTable();

        // A zero word in SYNC drops back to HUNT; the next word only seeds
        phase = "sync_zero";
        vecs.push_back(rv());
        vecs.push_back(wv(16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(wv(16'hACA4, 0, 0, 0, 0));
        vecs.push_back(wv(16'h0000, 0, 0, 0, 0));
        vecs.push_back(wv(16'h5652, 0, 0, 0, 0));
        vecs.push_back(wv(16'h2B29, 0, 0, 0, 0));
        vecs.push_back(wv(16'hC6CF, 0, 0, 0, 0));
        vecs.push_back(wv(16'hB03C, 0, 0, 0, 0));
        vecs.push_back(wv(16'h581E, 1, 0, 0, 0));
        runTable();

        // Bubbles between words only stretch the lock timing
        phase = "bubbles";
        vecs.push_back(rv());
        vecs.push_back(wv(16'hFFFF, 0, 0, 0, 0));
        vecs.push_back(iv(0, 0, 0, 0));
        vecs.push_back(wv(16'hACA4, 0, 0, 0, 0));
        vecs.push_back(iv(0, 0, 0, 0));
        vecs.push_back(iv(0, 0, 0, 0));
        vecs.push_back(wv(16'h5652, 0, 0, 0, 0));
        vecs.push_back(wv(16'h2B29, 0, 0, 0, 0));
        vecs.push_back(iv(0, 0, 0, 0));
        vecs.push_back(wv(16'hC6CF, 1, 0, 0, 0));
        runTable();

        // Saturation: pairs of single-bit errors separated by a good word
        phase = "saturate";
        nxt = 16'hB03C;
        n   = 0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 2; k++) begin
                n++;
                sat = (n > 15) ? 15 : n;
                cycle(wv(nxt ^ 16'h0001, 1, 1, sat, sat));
                nxt = lfsr_step(nxt);
            end
            cycle(wv(nxt, 1, 0, sat, sat));
            nxt = lfsr_step(nxt);
        end

        // Clear in the same cycle as an error loads that error alone
        phase = "clear_err";
        cycle(mk(0, 1, 1, nxt ^ 16'h0001, 1, 1, 1, 1));
        nxt = lfsr_step(nxt);
        cycle(mk(0, 1, 1, nxt ^ 16'h00FF, 1, 1, 1, 8));
        nxt = lfsr_step(nxt);
        cycle(wv(nxt, 1, 0, 1, 8));
        nxt = lfsr_step(nxt);

        // Reset with a bad valid word wins over everything
        phase = "mid_reset";
        cycle(mk(1, 1, 0, nxt ^ 16'h0001, 0, 0, 0, 0));
        cycle(wv(lfsr_step(nxt), 0, 0, 0, 0));
        cycle(iv(0, 0, 0, 0));

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
